// File: rtl/pipeline_control_pkg.sv
// Shared types for the pipeline hazard/stall controller.
package pipeline_control_pkg;

    // Control pair for one pipeline latch. Never drive update and flush together.
    typedef struct packed {
        logic update;
        logic flush;
    } pipe_ctrl_t;

    // Controller states. HALTED can only be left through reset.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

    localparam pipe_ctrl_t LATCH_UPDATE = '{update: 1'b1, flush: 1'b0};
    localparam pipe_ctrl_t LATCH_HOLD   = '{update: 1'b0, flush: 1'b0};
    localparam pipe_ctrl_t LATCH_FLUSH  = '{update: 1'b0, flush: 1'b1};

    // True when any of the four latches is being flushed this cycle.
    function automatic logic any_flush(input pipe_ctrl_t a, input pipe_ctrl_t b,
                                       input pipe_ctrl_t c, input pipe_ctrl_t d);
        return a.flush | b.flush | c.flush | d.flush;
    endfunction

endpackage

// File: rtl/pipeline_control_hazard.sv
// Combinational hazard detection and fixed-priority resolution of latch controls.
module pipeline_control_hazard
    import pipeline_control_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_ihit,
    input  logic             i_dhit,
    input  logic             i_em_dren,
    input  logic             i_em_dwen,
    input  logic             i_de_mem_to_reg,
    input  logic [REG_W-1:0] i_de_rt,
    input  logic [REG_W-1:0] i_fd_rs,
    input  logic [REG_W-1:0] i_fd_rt,
    input  logic             i_fd_uses_rt,
    input  logic             i_branch_taken_ex,
    input  logic             i_jr_ex,
    input  logic             i_jump_id,
    input  logic             i_de_halt,
    output logic             o_dmem_stall,
    output logic             o_pc_en,
    output pipe_ctrl_t       o_fd,
    output pipe_ctrl_t       o_de,
    output pipe_ctrl_t       o_em,
    output pipe_ctrl_t       o_mw
);

    logic w_lu_haz;

    // Hazard terms; register 0 never creates a load-use dependency.
    always_comb begin
        o_dmem_stall = (i_em_dren | i_em_dwen) & ~i_dhit;
        w_lu_haz     = i_de_mem_to_reg & (i_de_rt != '0) &
                       ((i_de_rt == i_fd_rs) | (i_fd_uses_rt & (i_de_rt == i_fd_rt)));
    end

    // Priority resolution: the first matching condition overrides the free-running defaults.
    always_comb begin
        o_pc_en = i_ihit;
        o_fd    = LATCH_UPDATE;
        o_de    = LATCH_UPDATE;
        o_em    = LATCH_UPDATE;
        o_mw    = LATCH_UPDATE;
        if (o_dmem_stall) begin
            // Hold everything upstream of MEM; bubble WB so the stalled op is not written twice.
            o_pc_en = 1'b0;
            o_fd    = LATCH_HOLD;
            o_de    = LATCH_HOLD;
            o_em    = LATCH_HOLD;
            o_mw    = LATCH_FLUSH;
        end else if (i_de_halt) begin
            o_pc_en = 1'b0;
            o_fd    = LATCH_FLUSH;
            o_de    = LATCH_FLUSH;
        end else if (i_branch_taken_ex | i_jr_ex) begin
            // PC loads the redirect target even without a valid instruction word.
            o_pc_en = 1'b1;
            o_fd    = LATCH_FLUSH;
            o_de    = LATCH_FLUSH;
        end else if (w_lu_haz) begin
            o_pc_en = 1'b0;
            o_fd    = LATCH_HOLD;
            o_de    = LATCH_FLUSH;
        end else if (i_jump_id) begin
            o_pc_en = 1'b1;
            o_fd    = LATCH_FLUSH;
        end else if (!i_ihit) begin
            o_pc_en = 1'b0;
            o_fd    = LATCH_FLUSH;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: run/halt state, output gating and performance counters.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             em_dren,
    input  logic             em_dwen,
    input  logic             de_mem_to_reg,
    input  logic [REG_W-1:0] de_rt,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rt,
    input  logic             branch_taken_ex,
    input  logic             jr_ex,
    input  logic             jump_id,
    input  logic             de_halt,
    input  logic             mw_halt,
    output logic             pc_en,
    output logic             fd_update,
    output logic             fd_flush,
    output logic             de_update,
    output logic             de_flush,
    output logic             em_update,
    output logic             em_flush,
    output logic             mw_update,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // state  | meaning
    // RUN    | pipeline controls follow the hazard priority rules
    // HALTED | halt retired; all controls low, counters frozen until reset

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    logic       w_dmem_stall;
    logic       w_hz_pc_en;
    pipe_ctrl_t w_hz_fd, w_hz_de, w_hz_em, w_hz_mw;
    logic       w_pc_en;
    pipe_ctrl_t w_fd, w_de, w_em, w_mw;

    pipeline_control_hazard #(
        .REG_W (REG_W)
    ) u_hazard (
        .i_ihit            (ihit),
        .i_dhit            (dhit),
        .i_em_dren         (em_dren),
        .i_em_dwen         (em_dwen),
        .i_de_mem_to_reg   (de_mem_to_reg),
        .i_de_rt           (de_rt),
        .i_fd_rs           (fd_rs),
        .i_fd_rt           (fd_rt),
        .i_fd_uses_rt      (fd_uses_rt),
        .i_branch_taken_ex (branch_taken_ex),
        .i_jr_ex           (jr_ex),
        .i_jump_id         (jump_id),
        .i_de_halt         (de_halt),
        .o_dmem_stall      (w_dmem_stall),
        .o_pc_en           (w_hz_pc_en),
        .o_fd              (w_hz_fd),
        .o_de              (w_hz_de),
        .o_em              (w_hz_em),
        .o_mw              (w_hz_mw)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    // Next state; a halt in WB retires only once any data access has completed.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RUN && mw_halt && !w_dmem_stall) w_state_nxt = HALTED;
    end

    // Output gating: HALTED forces every control low.
    always_comb begin
        w_pc_en = w_hz_pc_en;
        w_fd    = w_hz_fd;
        w_de    = w_hz_de;
        w_em    = w_hz_em;
        w_mw    = w_hz_mw;
        if (r_state == HALTED) begin
            w_pc_en = 1'b0;
            w_fd    = LATCH_HOLD;
            w_de    = LATCH_HOLD;
            w_em    = LATCH_HOLD;
            w_mw    = LATCH_HOLD;
        end
    end

    // Performance counters, advancing only in RUN and wrapping naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (r_state == RUN) begin
            if (!w_pc_en) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (any_flush(w_fd, w_de, w_em, w_mw)) r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign pc_en        = w_pc_en;
    assign fd_update    = w_fd.update;
    assign fd_flush     = w_fd.flush;
    assign de_update    = w_de.update;
    assign de_flush     = w_de.flush;
    assign em_update    = w_em.update;
    assign em_flush     = w_em.flush;
    assign mw_update    = w_mw.update;
    assign mw_flush     = w_mw.flush;
    assign halted       = (r_state == HALTED);
    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: vector table, directed sequences, random vs. model.
module tb_pipeline_control;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, em_dren, em_dwen, de_mem_to_reg, fd_uses_rt;
    logic [4:0] de_rt, fd_rs, fd_rt;
    logic       branch_taken_ex, jr_ex, jump_id, de_halt, mw_halt;
    logic       pc_en, fd_update, fd_flush, de_update, de_flush;
    logic       em_update, em_flush, mw_update, mw_flush, halted;
    logic [31:0] stall_cycles, flush_events;

    pipeline_control #(.CNT_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .em_dren(em_dren), .em_dwen(em_dwen),
        .de_mem_to_reg(de_mem_to_reg), .de_rt(de_rt), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .branch_taken_ex(branch_taken_ex), .jr_ex(jr_ex),
        .jump_id(jump_id), .de_halt(de_halt), .mw_halt(mw_halt), .pc_en(pc_en),
        .fd_update(fd_update), .fd_flush(fd_flush), .de_update(de_update), .de_flush(de_flush),
        .em_update(em_update), .em_flush(em_flush), .mw_update(mw_update), .mw_flush(mw_flush),
        .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 CLK = ~CLK;

    // {pc_en, fd_u, fd_f, de_u, de_f, em_u, em_f, mw_u, mw_f}
    logic [8:0] w_out;
    assign w_out = {pc_en, fd_update, fd_flush, de_update, de_flush,
                    em_update, em_flush, mw_update, mw_flush};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    bit          m_halted;
    logic [31:0] m_stall, m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected controls from the priority rules; per-latch action 0=update 1=hold 2=flush.
    function automatic logic [8:0] model_out();
        int  act[4];
        bit  pc;
        bit  dstall, lu;
        logic [8:0] r;
        if (m_halted) return 9'd0;
        dstall = (em_dren || em_dwen) && !dhit;
        lu = de_mem_to_reg && de_rt != 0 &&
             (de_rt == fd_rs || (fd_uses_rt && de_rt == fd_rt));
        pc = ihit;
        act = '{0, 0, 0, 0};
        if (dstall)                         begin pc = 0; act = '{1, 1, 1, 2}; end
        else if (de_halt)                   begin pc = 0; act = '{2, 2, 0, 0}; end
        else if (branch_taken_ex || jr_ex)  begin pc = 1; act = '{2, 2, 0, 0}; end
        else if (lu)                        begin pc = 0; act = '{1, 2, 0, 0}; end
        else if (jump_id)                   begin pc = 1; act = '{2, 0, 0, 0}; end
        else if (!ihit)                     begin pc = 0; act = '{2, 0, 0, 0}; end
        r[8] = pc;
        for (int k = 0; k < 4; k++) begin
            r[7-2*k] = (act[k] == 0);
            r[6-2*k] = (act[k] == 2);
        end
        return r;
    endfunction

    task automatic set_idle();
        ihit = 1; dhit = 0; em_dren = 0; em_dwen = 0; de_mem_to_reg = 0;
        de_rt = 0; fd_rs = 0; fd_rt = 0; fd_uses_rt = 0;
        branch_taken_ex = 0; jr_ex = 0; jump_id = 0; de_halt = 0; mw_halt = 0;
    endtask

    // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
    task automatic run_cycle(input string name);
        logic [8:0] exp;
        @(negedge CLK);
        exp = model_out();
        check(name, {23'd0, w_out}, {23'd0, exp});
        @(posedge CLK);
        if (!m_halted) begin
            if (!exp[8]) m_stall++;
            if (exp[6] | exp[4] | exp[2] | exp[0]) m_flush++;
            if (mw_halt && !((em_dren || em_dwen) && !dhit)) m_halted = 1;
        end
        #1;
        check({name, "_stall"},  stall_cycles, m_stall);
        check({name, "_flush"},  flush_events, m_flush);
        check({name, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
    endtask

    // Async reset pulse placed mid-cycle; counters must clear before any clock edge.
    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 0;
        #2;
        check("rst_stall",  stall_cycles, 32'd0);
        check("rst_flush",  flush_events, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        m_halted = 0; m_stall = 0; m_flush = 0;
        set_idle();
        @(posedge CLK); #1;
        nRST = 1;
    endtask

    typedef struct {
        logic       ihit, dhit, dren, dwen, mtr;
        logic [4:0] de_rt, fd_rs, fd_rt;
        logic       uses_rt, br, jr, jmp, dhalt;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ih, dh, dr, dw, mtr, input logic [4:0] drt, frs, frt,
                                input logic urt, br, jr, jmp, dhl, input logic [8:0] e);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.mtr = mtr;
        v.de_rt = drt; v.fd_rs = frs; v.fd_rt = frt; v.uses_rt = urt;
        v.br = br; v.jr = jr; v.jmp = jmp; v.dhalt = dhl; v.exp = e;
        return v;
    endfunction

    initial begin
        nRST = 0;
        set_idle();
        m_halted = 0; m_stall = 0; m_flush = 0;

        //           ih dh dr dw mtr drt frs frt urt br jr jmp dhl  expected
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 9'b1_10_10_10_10)); // normal
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 9'b0_01_10_10_10)); // imiss
        tbl.push_back(mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 9'b0_00_00_00_01)); // load wait
        tbl.push_back(mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 9'b0_00_00_00_01)); // store wait + br
        tbl.push_back(mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 9'b1_10_10_10_10)); // load done
        tbl.push_back(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 1, 9'b0_01_01_10_10)); // halt > br
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 9'b1_01_01_10_10)); // br, no ihit
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0, 0, 9'b1_01_01_10_10)); // jr > lu
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 1, 0, 9'b0_00_01_10_10)); // lu > jump
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 0, 9'b0_00_01_10_10)); // lu via rt
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0, 9'b1_10_10_10_10)); // rt unused
        tbl.push_back(mk(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 9'b1_10_10_10_10)); // r0 no hazard
        tbl.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 9'b1_01_10_10_10)); // jump

        // Reset then normal flow for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) run_cycle("normal");
        check("normal_stall0", stall_cycles, 32'd0);

        // Vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            ihit = tbl[i].ihit; dhit = tbl[i].dhit; em_dren = tbl[i].dren; em_dwen = tbl[i].dwen;
            de_mem_to_reg = tbl[i].mtr; de_rt = tbl[i].de_rt; fd_rs = tbl[i].fd_rs;
            fd_rt = tbl[i].fd_rt; fd_uses_rt = tbl[i].uses_rt; branch_taken_ex = tbl[i].br;
            jr_ex = tbl[i].jr; jump_id = tbl[i].jmp; de_halt = tbl[i].dhalt;
            #2;
            check($sformatf("vec%0d", i), {23'd0, w_out}, {23'd0, tbl[i].exp});
            run_cycle($sformatf("vec%0d_m", i));
        end

        // Load-use for one cycle from reset.
        do_reset();
        de_mem_to_reg = 1; de_rt = 5; fd_rs = 5;
        run_cycle("lu");
        set_idle();
        check("lu_stall1", stall_cycles, 32'd1);
        check("lu_flush1", flush_events, 32'd1);
        de_mem_to_reg = 1; de_rt = 0; fd_rs = 0;
        run_cycle("lu_r0");
        check("lu_r0_stall", stall_cycles, 32'd1);
        set_idle();

        // Data wait of three cycles with a pending taken branch, then dhit.
        do_reset();
        em_dren = 1; branch_taken_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("dwait_noflush", {30'd0, fd_flush, de_flush}, 32'd0);
            run_cycle("dwait");
        end
        check("dwait_stall3", stall_cycles, 32'd3);
        dhit = 1;
        #2;
        check("dwait_redirect", {30'd0, fd_flush, de_flush}, 32'd3);
        run_cycle("dwait_done");
        set_idle();

        // Two instruction-fetch misses.
        do_reset();
        ihit = 0;
        run_cycle("imiss");
        run_cycle("imiss");
        check("imiss_stall2", stall_cycles, 32'd2);
        check("imiss_flush2", flush_events, 32'd2);
        set_idle();

        // Halt drain, halt retire, frozen HALTED, reset release.
        de_halt = 1;
        run_cycle("dhalt");
        de_halt = 0;
        run_cycle("drain");
        mw_halt = 1;
        run_cycle("mwhalt");
        check("halted_set", {31'd0, halted}, 32'd1);
        mw_halt = 0; ihit = 0; jump_id = 1; em_dren = 1; de_halt = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("halted_ctrl", {23'd0, w_out}, 32'd0);
            run_cycle("halted");
        end
        check("halted_frozen_stall", stall_cycles, 32'd3);
        do_reset();
        run_cycle("post_halt");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (m_halted && $urandom_range(3) == 0) do_reset();
            ihit = ($urandom_range(3) != 0);
            dhit = ($urandom_range(2) != 0);
            em_dren = ($urandom_range(3) == 0);
            em_dwen = ($urandom_range(5) == 0);
            de_mem_to_reg = ($urandom_range(2) == 0);
            de_rt = 5'($urandom_range(3));
            fd_rs = 5'($urandom_range(3));
            fd_rt = 5'($urandom_range(3));
            fd_uses_rt = 1'($urandom_range(1));
            branch_taken_ex = ($urandom_range(7) == 0);
            jr_ex = ($urandom_range(11) == 0);
            jump_id = ($urandom_range(7) == 0);
            de_halt = ($urandom_range(15) == 0);
            mw_halt = ($urandom_range(39) == 0);
            run_cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
